// File: rtl/slice_chunk_scheduler.sv
// Grants one downstream slice-decode pipeline to per-slice chunk FIFOs,
// one whole chunk at a time in fixed slice order, line by line.
module slice_chunk_scheduler #(
    parameter  int MAX_NBR_SLICES = 2,
    localparam int SW = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_sof,
    input  logic [9:0]                    slices_per_line,
    input  logic [15:0]                   chunk_size,
    input  logic [15:0]                   slice_height,
    input  logic [MAX_NBR_SLICES-1:0]     fifo_empty,
    input  logic [256*MAX_NBR_SLICES-1:0] fifo_rd_data,
    output logic [MAX_NBR_SLICES-1:0]     fifo_rd_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [255:0]                  out_data,
    output logic [SW-1:0]                 out_slice_id,
    output logic                          out_first_word,
    output logic                          out_last_word,
    output logic                          out_slice_sof,
    output logic                          busy,
    output logic                          frame_done
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t        state, state_d;
    logic [SW-1:0] slice_idx, slice_idx_d;
    logic [11:0]   word_cnt, word_cnt_d;
    logic [15:0]   line_cnt, line_cnt_d;
    logic [9:0]    cfg_spl, cfg_spl_d;
    logic [11:0]   cfg_cw, cfg_cw_d;
    logic [15:0]   cfg_ht, cfg_ht_d;

    logic [9:0]    spl_clamp;
    logic [11:0]   cw_raw;
    logic [11:0]   cw_clamp;
    logic [15:0]   ht_clamp;

    always_comb begin
        spl_clamp = slices_per_line;
        if (slices_per_line == 10'd0)
            spl_clamp = 10'd1;
        else if (slices_per_line > 10'(MAX_NBR_SLICES))
            spl_clamp = 10'(MAX_NBR_SLICES);
    end

    assign cw_raw   = 12'((32'(chunk_size) + 32'd31) >> 5);
    assign cw_clamp = (cw_raw == 12'd0) ? 12'd1 : cw_raw;
    assign ht_clamp = (slice_height == 16'd0) ? 16'd1 : slice_height;

    logic word_last, slice_last, line_last;
    logic head_empty, reg_free, pop, frame_end;

    assign word_last  = (word_cnt == cfg_cw - 12'd1);
    assign slice_last = (10'(slice_idx) == cfg_spl - 10'd1);
    assign line_last  = (line_cnt == cfg_ht - 16'd1);
    assign head_empty = fifo_empty[slice_idx];
    assign reg_free   = ~out_valid | out_ready;

    // A restart or flush cycle never pops, so counters and FIFOs stay aligned
    assign pop = (state == XFER) & ~flush & ~in_sof & ~head_empty & reg_free;
    assign frame_end = pop & word_last & slice_last & line_last;

    assign fifo_rd_en = pop ? (MAX_NBR_SLICES'(1) << slice_idx)
                            : '0;
    assign busy = (state != IDLE);

    always_comb begin
        state_d     = state;
        slice_idx_d = slice_idx;
        word_cnt_d  = word_cnt;
        line_cnt_d  = line_cnt;
        cfg_spl_d   = cfg_spl;
        cfg_cw_d    = cfg_cw;
        cfg_ht_d    = cfg_ht;
        unique case (state)
            IDLE: begin
                if (in_sof) begin
                    state_d     = XFER;
                    slice_idx_d = '0;
                    word_cnt_d  = '0;
                    line_cnt_d  = '0;
                    cfg_spl_d   = spl_clamp;
                    cfg_cw_d    = cw_clamp;
                    cfg_ht_d    = ht_clamp;
                end
            end
            XFER: begin
                if (in_sof) begin
                    slice_idx_d = '0;
                    word_cnt_d  = '0;
                    line_cnt_d  = '0;
                    cfg_spl_d   = spl_clamp;
                    cfg_cw_d    = cw_clamp;
                    cfg_ht_d    = ht_clamp;
                end else if (pop) begin
                    word_cnt_d = word_cnt + 12'd1;
                    if (word_last) begin
                        word_cnt_d = '0;
                        if (slice_last) begin
                            slice_idx_d = '0;
                            line_cnt_d  = line_cnt + 16'd1;
                        end else begin
                            slice_idx_d = slice_idx + SW'(1);
                        end
                    end
                    if (frame_end) begin
                        state_d     = IDLE;
                        slice_idx_d = '0;
                        line_cnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            slice_idx_d = '0;
            word_cnt_d  = '0;
            line_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slice_idx <= '0;
            word_cnt  <= '0;
            line_cnt  <= '0;
            cfg_spl   <= 10'd1;
            cfg_cw    <= 12'd1;
            cfg_ht    <= 16'd1;
        end else begin
            state     <= state_d;
            slice_idx <= slice_idx_d;
            word_cnt  <= word_cnt_d;
            line_cnt  <= line_cnt_d;
            cfg_spl   <= cfg_spl_d;
            cfg_cw    <= cfg_cw_d;
            cfg_ht    <= cfg_ht_d;
        end
    end

    // Output register keeps draining after the frame ends, even in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_slice_id   <= '0;
            out_first_word <= 1'b0;
            out_last_word  <= 1'b0;
            out_slice_sof  <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (pop) begin
                out_valid      <= 1'b1;
                out_data       <= fifo_rd_data[{slice_idx, 8'd0} +: 256];
                out_slice_id   <= slice_idx;
                out_first_word <= (word_cnt == 12'd0);
                out_last_word  <= word_last;
                out_slice_sof  <= (line_cnt == 16'd0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slice_chunk_scheduler.sv
// Directed bench for slice_chunk_scheduler with a counting FWFT FIFO model.
module tb_slice_chunk_scheduler;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_sof = 1'b0;
    logic           out_ready = 1'b0;
    logic [9:0]     spl = '0;
    logic [15:0]    cs = '0;
    logic [15:0]    ht = '0;
    logic [N-1:0]   fifo_empty = '1;
    logic [256*N-1:0] rd_data;
    logic [N-1:0]   rd_en;
    logic           out_valid;
    logic [255:0]   out_data;
    logic [0:0]     out_slice_id;
    logic           out_first_word, out_last_word, out_slice_sof;
    logic           busy, frame_done;

    int checks = 0;
    int errors = 0;

    slice_chunk_scheduler #(.MAX_NBR_SLICES(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_sof(in_sof),
        .slices_per_line(spl), .chunk_size(cs), .slice_height(ht),
        .fifo_empty(fifo_empty), .fifo_rd_data(rd_data),
        .fifo_rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_slice_id(out_slice_id),
        .out_first_word(out_first_word), .out_last_word(out_last_word),
        .out_slice_sof(out_slice_sof), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // FIFO model: head word of slice s = {s, number of pops so far}
    int unsigned pcnt [N];
    always_comb begin
        rd_data = '0;
        for (int s = 0; s < N; s++)
            rd_data[s*256 +: 256] = {216'd0, 8'(s), 32'(pcnt[s])};
    end

    logic        clr = 1'b0;
    int          cyc = 0;
    int          pops, last_pop, fd_cyc, fd_n, cap_n, stab_err;
    logic        rd1_seen, held;
    logic [255:0] prev_data;
    logic [43:0] cap [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            for (int s = 0; s < N; s++) pcnt[s] <= 0;
            pops <= 0; last_pop <= -10; fd_cyc <= -1; fd_n <= 0;
            cap_n <= 0; stab_err <= 0; rd1_seen <= 1'b0; held <= 1'b0;
        end else begin
            for (int s = 0; s < N; s++)
                if (rd_en[s]) pcnt[s] <= pcnt[s] + 1;
            if (|rd_en) begin
                pops <= pops + 1;
                last_pop <= cyc;
            end
            if (rd_en[1]) rd1_seen <= 1'b1;
            if (out_valid && out_ready && cap_n < 64) begin
                cap[cap_n] <= {out_slice_id, out_first_word, out_last_word,
                               out_slice_sof, out_data[39:0]};
                cap_n <= cap_n + 1;
            end
            if (frame_done) begin
                fd_cyc <= cyc;
                fd_n <= fd_n + 1;
            end
            if (held && !(out_valid && out_data == prev_data))
                stab_err <= stab_err + 1;
            held <= out_valid && !out_ready;
            prev_data <= out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] word(input int id, input bit f,
                                        input bit l, input bit sof,
                                        input int s, input int idx);
        return {1'(id), f, l, sof, 8'(s), 32'(idx)};
    endfunction

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic start(input logic [9:0] p, input logic [15:0] c,
                         input logic [15:0] h);
        spl = p; cs = c; ht = h;
        in_sof = 1'b1;
        tick();
        in_sof = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done) begin
                seen = 1'b1;
                chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        int idx, s;
        // reset values
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rden", 64'(rd_en), 64'd0);
        chk("rst_outs", {out_data[59:0], out_slice_id, out_first_word,
                         out_last_word, out_slice_sof}, 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        fifo_empty = '0;
        out_ready = 1'b1;
        clear();

        // 2 slices, 4-word chunks, 2 lines
        start(10'd2, 16'd100, 16'd2);
        chk("a_busy", 64'(busy), 64'd1);
        wait_fd("a", 40);
        chk("a_pops", 64'(pops), 64'd16);
        chk("a_done_lat", 64'(fd_cyc), 64'(last_pop + 1));
        chk("a_caps", 64'(cap_n), 64'd16);
        for (int i = 0; i < 16; i++) begin
            s = (i / 4) % 2;
            idx = (i / 8) * 4 + i % 4;
            chk($sformatf("a_w%0d", i), 64'(cap[i]),
                64'(word(s, i % 4 == 0, i % 4 == 3, i < 8, s, idx)));
        end

        // 1 slice, 1-word chunks, 3 lines
        clear();
        start(10'd1, 16'd32, 16'd3);
        wait_fd("b", 20);
        chk("b_pops", 64'(pops), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b_w%0d", i), 64'(cap[i]),
                64'(word(0, 1, 1, i == 0, 0, i)));

        // slice 0 starved: no skipping ahead to slice 1
        clear();
        fifo_empty = 2'b01;
        start(10'd2, 16'd32, 16'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("c_nopop", 64'(pops), 64'd0);
        chk("c_no_rd1", 64'(rd1_seen), 64'd0);
        fifo_empty = '0;
        wait_fd("c", 20);
        chk("c_w0", 64'(cap[0]), 64'(word(0, 1, 1, 1, 0, 0)));
        chk("c_w1", 64'(cap[1]), 64'(word(1, 1, 1, 1, 1, 0)));

        // toggling backpressure
        clear();
        out_ready = 1'b0;
        start(10'd2, 16'd128, 16'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                out_ready = ~out_ready;
                tick();
                if (frame_done) seen = 1'b1;
            end
            chk("d_done_seen", 64'(seen), 64'd1);
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("d_pops", 64'(pops), 64'd8);
        chk("d_caps", 64'(cap_n), 64'd8);
        chk("d_stable", 64'(stab_err), 64'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("d_w%0d", i), 64'(cap[i]),
                64'(word(i / 4, i % 4 == 0, i % 4 == 3, 1, i / 4, i % 4)));

        // flush with in_sof mid-chunk
        clear();
        start(10'd2, 16'd128, 16'd1);
        tick();
        flush = 1'b1;
        in_sof = 1'b1;
        #1;
        chk("e_nopop_flush", 64'(rd_en), 64'd0);
        tick();
        flush = 1'b0;
        in_sof = 1'b0;
        chk("e_idle", 64'(busy), 64'd0);
        chk("e_valid", 64'(out_valid), 64'd0);
        tick();
        chk("e_still_idle", 64'(busy), 64'd0);
        clear();
        start(10'd2, 16'd128, 16'd1);
        wait_fd("e", 30);
        chk("e_caps", 64'(cap_n), 64'd8);
        chk("e_w0", 64'(cap[0]), 64'(word(0, 1, 0, 1, 0, 0)));

        // zero config fields clamp to 1
        clear();
        start(10'd0, 16'd0, 16'd0);
        wait_fd("f0", 20);
        chk("f0_pops", 64'(pops), 64'd1);
        chk("f0_w0", 64'(cap[0]), 64'(word(0, 1, 1, 1, 0, 0)));

        // spl above MAX clamps to MAX
        clear();
        start(10'd5, 16'd32, 16'd1);
        wait_fd("f5", 20);
        chk("f5_pops", 64'(pops), 64'd2);
        chk("f5_w1", 64'(cap[1]), 64'(word(1, 1, 1, 1, 1, 0)));

        // asynchronous reset mid-frame
        clear();
        start(10'd2, 16'd128, 16'd2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_valid", 64'(out_valid), 64'd0);
        chk("r_rden", 64'(rd_en), 64'd0);
        chk("r_data", 64'(out_data[63:0]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_chunk_scheduler.md
# slice_chunk_scheduler

Decoder-side scheduler that shares one downstream slice-decode pipeline among the per-slice chunk FIFOs filled by the slice demultiplexer. It grants the pipeline one whole chunk at a time, in fixed slice order (0,1,…,slices_per_line-1), once per line, for slice_height lines per frame. Each forwarded 256-bit word carries slice id, first/last-of-chunk and first-chunk-of-slice tags. The scheduler sits between the per-slice FIFOs and the substream demux / decoder core.

## Interface
- MAX_NBR_SLICES, 2: number of per-slice FIFOs; SW = max(1, $clog2(MAX_NBR_SLICES)).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort, returns to IDLE.
- in_sof  in  1  start-of-frame pulse; samples config and starts the frame.
- slices_per_line  in  10  slices per line; 0 is treated as 1, values above MAX_NBR_SLICES as MAX_NBR_SLICES.
- chunk_size  in  16  chunk size in bytes.
- slice_height  in  16  lines per slice; 0 is treated as 1.
- fifo_empty  in  MAX_NBR_SLICES  per-slice FWFT FIFO empty flags.
- fifo_rd_data  in  256*MAX_NBR_SLICES  per-slice FWFT head word, slice s at [s*256+:256].
- fifo_rd_en  out  MAX_NBR_SLICES  one-hot pop, combinational from registered state and inputs.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  256  output word.
- out_slice_id  out  SW  source slice of out_data.
- out_first_word / out_last_word  out  1 each  first / last word of a chunk.
- out_slice_sof  out  1  word belongs to line 0 of its slice.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the frame's final word is popped.

## Operation
- Config (clamped spl, slice_height, chunk words) is latched at in_sof. chunk_words = ceil(chunk_size/32), with a minimum of 1. The latched value is 12 bits; upper bits are truncated.
- States:
  - IDLE: no pops. in_sof -> XFER, with slice_idx=0, word_cnt=0, line_cnt=0.
  - XFER: pop condition = ~fifo_empty[slice_idx] & (~out_valid | out_ready).
    - On a pop: fifo_rd_en[slice_idx]=1; the output register loads fifo_rd_data[slice_idx] and the tags.
    - word_cnt increments on each pop. A pop with word_cnt==chunk_words-1 ends the chunk: word_cnt=0, and slice_idx advances.
    - slice_idx wraps at spl-1 to 0, and line_cnt increments on the wrap.
    - The end of the chunk of the last slice on line slice_height-1 is the frame end: next state IDLE, and frame_done is pulsed next cycle.
- No skipping: if the current slice's FIFO is empty, the scheduler waits on it. This preserves decode order.
- Tags are registered with the data:
  - out_first_word = (word_cnt==0).
  - out_last_word = (word_cnt==chunk_words-1); both are 1 when chunk_words==1.
  - out_slice_sof = (line_cnt==0).
  - out_slice_id = slice_idx.
- Output register: out_valid is set on a pop. It is cleared when out_ready & ~pop. It holds data and tags stable while out_valid & ~out_ready.
- The output register drains after the final pop, even in IDLE.
- in_sof in XFER is a restart: counters are zeroed, config is relatched, and there is no frame_done. out_valid keeps any held word until it is accepted.
- flush: next cycle state=IDLE, counters=0, out_valid=0, no pop in the flush cycle. flush has priority over in_sof in the same cycle.
- fifo_rd_en bits for slices >= spl are never asserted.

## Timing
- Reset values:
  - fifo_rd_en=0, out_valid=0, out_data=0, out_slice_id=0.
  - out_first_word=0, out_last_word=0, out_slice_sof=0.
  - busy=0, frame_done=0, state IDLE, all counters 0.
- Cycle after in_sof: busy=1. The first pop can occur in that cycle.
- Pop to out_valid: 1 cycle.
- Throughput: 1 word/cycle with out_ready=1 and non-empty FIFOs. Chunk boundaries insert no bubbles.
- Backpressure: with out_valid=1 and out_ready=0, pops occur only when the register is free, so there is no pop that cycle.
- frame_done and busy=0 appear in the same cycle, 1 cycle after the final pop.
- rst_n assertion mid-frame forces reset values immediately (asynchronously), with no pops.

## Test plan
- spl=2, chunk_size=100 (4 words), slice_height=2, FIFOs full, out_ready=1 -> 16 words in slice order 0,0,0,0,1,1,1,1,0,…; first/last tags on words 0/3 of each chunk; out_slice_sof=1 on the first 8 words only; frame_done 1 cycle after pop 16.
- spl=1, chunk_size=32 -> every word has first=last=1 and slice_id=0; slice_height=3 gives exactly 3 pops, then IDLE.
- fifo_empty[0]=1 for 5 cycles at frame start while slice 1 is full -> no pops from slice 1 and no fifo_rd_en[1]; the sequence resumes with slice 0.
- out_ready toggled 0/1 every cycle -> out_data stable while stalled; no word is lost or duplicated, checked via FIFO pop count = 8 for spl=2, 4-word chunks, 1 line.
- flush asserted mid-chunk together with in_sof -> next cycle IDLE, out_valid=0; a subsequent in_sof restarts at slice 0, word 0.
- Config edge cases: slices_per_line=0 behaves as 1; slices_per_line=5 with MAX_NBR_SLICES=2 behaves as 2; chunk_size=0 behaves as 1 word; slice_height=0 behaves as 1 line.
